arp_responder: RTL and testbench
================================

// Module: arp_responder
// PURPOSE
//  Responder side of ARP: consumes frames delivered by eth_rx (eth_send_packet/eth_packet),
//  recognises ARP requests for this node's IP and builds the ARP reply frame for eth_tx.
//  Sits between eth_rx and eth_tx and replaces the fixed-delay loopback trigger.
//  Includes a 1-deep pending slot, a TX hold-off timer and saturating statistics counters.
// PARAMETERS
//  MY_MAC         48'h106530703d6d  node MAC address (reply sender MAC, unicast match)
//  MY_IP          32'h0a1f55ff      node IPv4 address (matched against request TPA)
//  TX_GAP_CYCLES  400               eth_clk cycles after a tx_transmit pulse before the next one is allowed
// PORTS
//  eth_clk        in   1    50 MHz RMII clock, single clock domain
//  rst_in         in   1    asynchronous, active-high reset
//  rx_valid       in   1    1-cycle pulse: rx_packet holds a complete frame (from eth_rx eth_send_packet)
//  rx_packet      in   480  st_eth_packet {dst[479:432], src[431:384], type[383:368], payload[367:0]}
//  tx_transmit    out  1    1-cycle pulse to eth_tx .transmit
//  tx_packet      out  480  st_eth_packet reply frame to eth_tx .eth_packet
//  busy           out  1    high whenever state != IDLE
//  reply_count    out  16   replies sent, saturating at 16'hFFFF
//  drop_count     out  16   requests lost to overflow, saturating
//  ignore_count   out  16   frames received that failed matching, saturating
// BEHAVIOUR
//  Reset (async): state=IDLE, tx_transmit=0, tx_packet=0, busy=0, all counters=0, pending slot empty.
//  Payload fields (bit offsets from payload MSB): htype[0:15] ptype[16:31] hlen[32:39] plen[40:47]
//   oper[48:63] sha[64:111] spa[112:143] tha[144:191] tpa[192:223] pad[224:367].
//  Match = type==16'h0806 & htype==1 & ptype==16'h0800 & hlen==6 & plen==4 & oper==1
//   & tpa==MY_IP & (dst==MY_MAC | dst==48'hFFFFFFFFFFFF).
//  States: IDLE, CHECK, SEND, HOLDOFF.
//   IDLE: rx_valid -> capture rx_packet into work register, go CHECK.
//   CHECK (1 cycle): match -> load tx_packet, go SEND; no match -> ignore_count++, go IDLE
//     (or CHECK again with pending frame if slot full; slot then cleared).
//   SEND (1 cycle): tx_transmit=1, reply_count++, load hold-off counter = TX_GAP_CYCLES-1, go HOLDOFF.
//   HOLDOFF: decrement to 0; at 0 -> pending full ? load pending, go CHECK : go IDLE.
//  Latency: rx_valid in cycle N, idle, matching -> tx_transmit high in cycle N+2.
//  Pulse spacing: consecutive tx_transmit pulses are >= TX_GAP_CYCLES+1 cycles apart.
//  Reply frame: dst=req.sha, src=MY_MAC, type=16'h0806; payload = 16'h0001, 16'h0800,
//   8'h06, 8'h04, 16'h0002, MY_MAC, MY_IP, req.sha, req.spa, 144'h0.
//  tx_packet changes only on CHECK->SEND; held stable through HOLDOFF and IDLE.
//  rx_valid while state != IDLE: slot empty -> store frame in pending slot;
//   slot full -> frame discarded, drop_count++ (all frames counted, matching unevaluated).
//  rx_valid in the same cycle HOLDOFF reaches 0 with slot full: pending frame proceeds to CHECK,
//   new frame is stored into the slot it vacates (not dropped).
//  Ignore/drop/reply counters saturate; no wrap.
//  rst_in mid-operation: immediate return to reset values; no tx_transmit pulse is emitted
//   for any captured or pending frame.
// TESTING
//  1 Request {dst=106530703d6d, src=123456789abc, type=0806, sha=704d7b63188f, spa=0a1f556a,
//    tpa=0a1f55ff} -> tx_transmit at N+2; tx_packet dst=704d7b63188f, src=106530703d6d,
//    oper=0002, sha=106530703d6d, spa=0a1f55ff, tha=704d7b63188f, tpa=0a1f556a, pad=0; reply_count=1.
//  2 Same request with dst=FFFFFFFFFFFF -> identical reply; with tpa=0a1f5501 -> no pulse,
//    ignore_count=1; with type=0800 (IPv4) -> no pulse, ignore_count=2.
//  3 Three matching requests 5 cycles apart -> pulses at N+2 and N+2+TX_GAP_CYCLES+1 (2nd via
//    pending slot); 3rd dropped, drop_count=1, reply_count=2.
//  4 Assert rst_in during HOLDOFF with slot full -> all outputs zero immediately, no further pulse.
//  5 Loopback eth_rx->arp_responder->eth_tx with test-1 frame -> eth_tx emits the reply frame
//    on eth_txd with eth_txen high; no spurious pulse for oper=0002 frames (ignore_count++).

Source files
------------

// File: rtl/arp_responder.sv
// ---------------------------------------------------------------------------
// arp_responder
//   Sits between eth_rx and eth_tx. It takes every frame that eth_rx delivers,
//   recognises ARP requests for this node's IP address, and builds the ARP
//   reply frame that eth_tx transmits. A one-deep pending slot buffers one
//   frame that arrives while a frame is already in progress. A hold-off timer
//   spaces the transmit pulses apart. Saturating counters record the replies
//   sent, the frames ignored and the frames dropped.
//
//   Handshake: rx_valid is a one-cycle strobe. rx_packet is sampled only in
//   that cycle. The block never back-pressures. tx_transmit is a one-cycle
//   strobe, and tx_packet is stable from that cycle until the next reply is
//   built.
//
// Ports
//   eth_clk       in   RMII clock, the only clock domain
//   rst_in        in   asynchronous, active-high reset
//   rx_valid      in   strobe: rx_packet holds a complete frame
//   rx_packet     in   {dst[479:432], src[431:384], type[383:368], payload}
//   tx_transmit   out  strobe to eth_tx: send tx_packet
//   tx_packet     out  reply frame
//   busy          out  high whenever the FSM is not in IDLE
//   reply_count   out  replies sent (saturating)
//   drop_count    out  frames lost because the pending slot was full (saturating)
//   ignore_count  out  evaluated frames that were not requests for us (saturating)
//   state_dbg     out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module arp_responder #(
   parameter logic [47:0] MY_MAC        = 48'h106530703d6d,
   parameter logic [31:0] MY_IP         = 32'h0a1f55ff,
   parameter int unsigned TX_GAP_CYCLES = 400
) (
   input  logic         eth_clk,
   input  logic         rst_in,
   input  logic         rx_valid,
   input  logic [479:0] rx_packet,
   output logic         tx_transmit,
   output logic [479:0] tx_packet,
   output logic         busy,
   output logic [15:0]  reply_count,
   output logic [15:0]  drop_count,
   output logic [15:0]  ignore_count,
   output logic [1:0]   state_dbg
);

   localparam int CW = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(TX_GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      SEND    = 2'd2,
      HOLDOFF = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [479:0]    work;
   logic [479:0]    pend;
   logic            pend_full;
   logic [CW-1:0]   hold_cnt;

   // Control strobes produced by the next-state logic.
   logic take_rx, take_pend, tx_load, hold_load;
   logic inc_reply, inc_ignore;
   logic store_pend, inc_drop;

   // Fields of the frame under evaluation.
   logic [47:0] w_dst, w_sha;
   logic [15:0] w_type, w_htype, w_ptype, w_oper;
   logic [7:0]  w_hlen, w_plen;
   logic [31:0] w_spa, w_tpa;
   logic        match;
   logic [479:0] reply;
   logic        unused_fields;

   assign w_dst   = work[479:432];
   assign w_type  = work[383:368];
   assign w_htype = work[367:352];
   assign w_ptype = work[351:336];
   assign w_hlen  = work[335:328];
   assign w_plen  = work[327:320];
   assign w_oper  = work[319:304];
   assign w_sha   = work[303:256];
   assign w_spa   = work[255:224];
   assign w_tpa   = work[175:144];
   // The source MAC, target MAC and padding play no part in the reply.
   assign unused_fields = ^{work[431:384], work[223:176], work[143:0]};

   assign match = (w_type == 16'h0806) && (w_htype == 16'h0001) &&
                  (w_ptype == 16'h0800) && (w_hlen == 8'h06) &&
                  (w_plen == 8'h04) && (w_oper == 16'h0001) &&
                  (w_tpa == MY_IP) &&
                  ((w_dst == MY_MAC) || (w_dst == 48'hFFFF_FFFF_FFFF));

   assign reply = {w_sha, MY_MAC, 16'h0806,
                   16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                   MY_MAC, MY_IP, w_sha, w_spa, 144'h0};

   assign tx_transmit = (state == SEND);
   assign busy        = (state != IDLE);
   assign state_dbg   = state;

   always_comb begin
      state_n    = state;
      take_rx    = 1'b0;
      take_pend  = 1'b0;
      tx_load    = 1'b0;
      hold_load  = 1'b0;
      inc_reply  = 1'b0;
      inc_ignore = 1'b0;
      case (state)
         IDLE: begin
            // The slot can be full here only if a frame arrived during the
            // last CHECK or HOLDOFF cycle. Drain the slot before taking rx.
            if (pend_full) begin
               take_pend = 1'b1;
               state_n   = CHECK;
            end else if (rx_valid) begin
               take_rx = 1'b1;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (match) begin
               tx_load = 1'b1;
               state_n = SEND;
            end else begin
               inc_ignore = 1'b1;
               if (pend_full) begin
                  take_pend = 1'b1;
                  state_n   = CHECK;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         SEND: begin
            inc_reply = 1'b1;
            hold_load = 1'b1;
            state_n   = HOLDOFF;
         end
         HOLDOFF: begin
            // Leave on the cycle the counter steps down to zero. This makes
            // the transmit pulses exactly TX_GAP_CYCLES+1 cycles apart when a
            // pending frame is waiting.
            if (hold_cnt <= CW'(1)) begin
               if (pend_full) begin
                  take_pend = 1'b1;
                  state_n   = CHECK;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A frame that is not taken straight into work goes to the slot. It can
   // use the slot if the slot is empty or is being emptied this same cycle.
   // Otherwise the frame is lost.
   assign store_pend = rx_valid && !take_rx && (!pend_full || take_pend);
   assign inc_drop   = rx_valid && !take_rx && pend_full && !take_pend;

   always_ff @(posedge eth_clk or posedge rst_in) begin
      if (rst_in) begin
         state        <= IDLE;
         work         <= '0;
         pend         <= '0;
         pend_full    <= 1'b0;
         hold_cnt     <= '0;
         tx_packet    <= '0;
         reply_count  <= '0;
         drop_count   <= '0;
         ignore_count <= '0;
      end else begin
         state <= state_n;

         if (take_rx) begin
            work <= rx_packet;
         end else if (take_pend) begin
            work <= pend;
         end

         if (store_pend) begin
            pend      <= rx_packet;
            pend_full <= 1'b1;
         end else if (take_pend) begin
            pend_full <= 1'b0;
         end

         if (hold_load) begin
            hold_cnt <= HOLD_LOAD;
         end else if ((state == HOLDOFF) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
         end

         if (tx_load) begin
            tx_packet <= reply;
         end

         if (inc_reply && (reply_count != 16'hFFFF)) begin
            reply_count <= reply_count + 16'd1;
         end
         if (inc_ignore && (ignore_count != 16'hFFFF)) begin
            ignore_count <= ignore_count + 16'd1;
         end
         if (inc_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_arp_responder.sv
// ---------------------------------------------------------------------------
// tb_arp_responder
//   Self-checking bench for arp_responder. The reference model works on named
//   ARP fields. It decides from the field values whether a frame is a request
//   for this node. It builds the expected reply field by field. It predicts
//   the cycles of the transmit pulses from the request cycle and the gap
//   between pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arp_responder;

   localparam logic [47:0] MY_MAC = 48'h106530703d6d;
   localparam logic [31:0] MY_IP  = 32'h0a1f55ff;
   localparam int          TX_GAP = 400;

   typedef struct packed {
      logic [47:0]  dst;
      logic [47:0]  src;
      logic [15:0]  typ;
      logic [15:0]  htype;
      logic [15:0]  ptype;
      logic [7:0]   hlen;
      logic [7:0]   plen;
      logic [15:0]  oper;
      logic [47:0]  sha;
      logic [31:0]  spa;
      logic [47:0]  tha;
      logic [31:0]  tpa;
      logic [143:0] pad;
   } frame_t;

   logic         eth_clk = 1'b0;
   logic         rst_in;
   logic         rx_valid;
   logic [479:0] rx_packet;
   logic         tx_transmit;
   logic [479:0] tx_packet;
   logic         busy;
   logic [15:0]  reply_count, drop_count, ignore_count;
   logic [1:0]   state_dbg;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int exp_reply = 0, exp_drop = 0, exp_ignore = 0;
   logic [479:0] last_reply = '0;

   // Scoreboard: expected replies and their cycles; observed pulses.
   logic [479:0] exp_q[$];
   int           exp_cyc_q[$];
   logic [479:0] obs_pkt_q[$];
   int           obs_cyc_q[$];

   arp_responder #(
      .MY_MAC(MY_MAC),
      .MY_IP(MY_IP),
      .TX_GAP_CYCLES(TX_GAP)
   ) dut (
      .eth_clk(eth_clk),
      .rst_in(rst_in),
      .rx_valid(rx_valid),
      .rx_packet(rx_packet),
      .tx_transmit(tx_transmit),
      .tx_packet(tx_packet),
      .busy(busy),
      .reply_count(reply_count),
      .drop_count(drop_count),
      .ignore_count(ignore_count),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #10 eth_clk = ~eth_clk;
   always @(posedge eth_clk) cyc <= cyc + 1;

   always @(negedge eth_clk) begin
      if (tx_transmit === 1'b1) begin
         obs_cyc_q.push_back(cyc);
         obs_pkt_q.push_back(tx_packet);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic frame_t req_frame(input logic [47:0] dst, input logic [47:0] sha,
                                        input logic [31:0] spa, input logic [31:0] tpa);
      frame_t f;
      f.dst = dst;           f.src = 48'h123456789abc; f.typ = 16'h0806;
      f.htype = 16'h0001;    f.ptype = 16'h0800;       f.hlen = 8'd6;
      f.plen = 8'd4;         f.oper = 16'h0001;        f.sha = sha;
      f.spa = spa;           f.tha = 48'h0;            f.tpa = tpa;
      f.pad = '0;
      return f;
   endfunction

   function automatic bit ref_match(input frame_t f);
      return (f.typ == 16'h0806) && (f.htype == 16'd1) && (f.ptype == 16'h0800) &&
             (f.hlen == 8'd6) && (f.plen == 8'd4) && (f.oper == 16'd1) &&
             (f.tpa == MY_IP) && ((f.dst == MY_MAC) || (f.dst == 48'hFFFFFFFFFFFF));
   endfunction

   function automatic frame_t ref_reply(input frame_t q);
      frame_t r;
      r.dst = q.sha;         r.src = MY_MAC;           r.typ = 16'h0806;
      r.htype = 16'h0001;    r.ptype = 16'h0800;       r.hlen = 8'h06;
      r.plen = 8'h04;        r.oper = 16'h0002;        r.sha = MY_MAC;
      r.spa = MY_IP;         r.tha = q.sha;            r.tpa = q.spa;
      r.pad = '0;
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_cycles(input int k);
      for (int i = 0; i < k; i++) @(posedge eth_clk);
   endtask

   // Presents one frame for one cycle; n is the number of that cycle.
   task automatic send_frame(input frame_t f, output int n);
      @(posedge eth_clk);
      #1;
      rx_valid  = 1'b1;
      rx_packet = f;
      n = cyc;
      @(posedge eth_clk);
      #1;
      rx_valid  = 1'b0;
      rx_packet = {15{$urandom()}};
   endtask

   task automatic clear_sb;
      exp_q.delete(); exp_cyc_q.delete();
      obs_pkt_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      @(negedge eth_clk);
      while (busy === 1'b1 && k < 3000) begin
         @(negedge eth_clk);
         k++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle_timeout busy=%b exp=0", tag, busy);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_in = 1'b1; rx_valid = 1'b0; rx_packet = '0;
      wait_cycles(3);
      #1 rst_in = 1'b0;
      @(negedge eth_clk);
      checks++;
      if ({tx_transmit, busy, state_dbg} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000", {tx_transmit, busy, state_dbg});
      end
      checks++;
      if (tx_packet !== 480'h0) begin
         failures++;
         $display("FAIL reset_tx_packet got=%h exp=0", tx_packet);
      end
      checks++;
      if ({reply_count, drop_count, ignore_count} !== 48'h0) begin
         failures++;
         $display("FAIL reset_counters got=%h exp=0", {reply_count, drop_count, ignore_count});
      end
   endtask

   task automatic test_unicast;
      frame_t f;
      int n;
      clear_sb();
      f = req_frame(MY_MAC, 48'h704d7b63188f, 32'h0a1f556a, 32'h0a1f55ff);
      send_frame(f, n);
      exp_q.push_back(ref_reply(f)); exp_cyc_q.push_back(n + 2); exp_reply++;
      last_reply = ref_reply(f);
      wait_cycles(4);
      checks++;
      if (obs_cyc_q.size() != exp_cyc_q.size()) begin
         failures++;
         $display("FAIL unicast_pulse_count got=%0d exp=%0d", obs_cyc_q.size(), exp_cyc_q.size());
      end else foreach (exp_cyc_q[i]) begin
         checks++;
         if (obs_cyc_q[i] != exp_cyc_q[i]) begin
            failures++;
            $display("FAIL unicast_latency got=%0d exp=%0d", obs_cyc_q[i], exp_cyc_q[i]);
         end
         checks++;
         if (obs_pkt_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL unicast_reply got=%h exp=%h", obs_pkt_q[i], exp_q[i]);
         end
      end
      checks++;
      if (reply_count !== 16'(exp_reply)) begin
         failures++;
         $display("FAIL unicast_reply_count got=%0d exp=%0d", reply_count, exp_reply);
      end
      wait_idle("unicast");
   endtask

   task automatic test_filtering;
      frame_t f, b;
      int n;
      clear_sb();
      b = req_frame(48'hFFFFFFFFFFFF, 48'h704d7b63188f, 32'h0a1f556a, 32'h0a1f55ff);
      send_frame(b, n);
      exp_q.push_back(ref_reply(b)); exp_cyc_q.push_back(n + 2); exp_reply++;
      last_reply = ref_reply(b);
      wait_idle("bcast");
      // Three frames that must not match: wrong TPA, IPv4 ethertype, an ARP reply.
      for (int k = 0; k < 3; k++) begin
         f = b;
         if (k == 0) f.tpa = 32'h0a1f5501;
         if (k == 1) f.typ = 16'h0800;
         if (k == 2) f.oper = 16'h0002;
         send_frame(f, n);
         exp_ignore++;
         wait_cycles(4);
         checks++;
         if (ignore_count !== 16'(exp_ignore)) begin
            failures++;
            $display("FAIL filter_ignore_count case=%0d got=%0d exp=%0d", k, ignore_count, exp_ignore);
         end
      end
      checks++;
      if (obs_cyc_q.size() != exp_cyc_q.size()) begin
         failures++;
         $display("FAIL filter_pulse_count got=%0d exp=%0d", obs_cyc_q.size(), exp_cyc_q.size());
      end else foreach (exp_cyc_q[i]) begin
         checks++;
         if (obs_cyc_q[i] != exp_cyc_q[i]) begin
            failures++;
            $display("FAIL bcast_latency got=%0d exp=%0d", obs_cyc_q[i], exp_cyc_q[i]);
         end
         checks++;
         if (obs_pkt_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL bcast_reply got=%h exp=%h", obs_pkt_q[i], exp_q[i]);
         end
      end
      checks++;
      if (tx_packet !== last_reply) begin
         failures++;
         $display("FAIL filter_tx_hold got=%h exp=%h", tx_packet, last_reply);
      end
   endtask

   task automatic test_back_to_back;
      frame_t f[3];
      int n[3];
      clear_sb();
      for (int k = 0; k < 3; k++)
         f[k] = req_frame(MY_MAC, {16'h0200, $urandom()}, $urandom(), MY_IP);
      send_frame(f[0], n[0]);
      wait_cycles(3);
      send_frame(f[1], n[1]);
      wait_cycles(3);
      send_frame(f[2], n[2]);
      exp_q.push_back(ref_reply(f[0])); exp_cyc_q.push_back(n[0] + 2);
      exp_q.push_back(ref_reply(f[1])); exp_cyc_q.push_back(n[0] + 2 + TX_GAP + 1);
      exp_reply += 2; exp_drop++;
      last_reply = ref_reply(f[1]);
      wait_cycles(2 * TX_GAP + 20);
      checks++;
      if (obs_cyc_q.size() != exp_cyc_q.size()) begin
         failures++;
         $display("FAIL b2b_pulse_count got=%0d exp=%0d", obs_cyc_q.size(), exp_cyc_q.size());
      end else foreach (exp_cyc_q[i]) begin
         checks++;
         if (obs_cyc_q[i] != exp_cyc_q[i]) begin
            failures++;
            $display("FAIL b2b_pulse_cycle idx=%0d got=%0d exp=%0d", i, obs_cyc_q[i], exp_cyc_q[i]);
         end
         checks++;
         if (obs_pkt_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL b2b_reply idx=%0d got=%h exp=%h", i, obs_pkt_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({reply_count, drop_count, ignore_count} !==
          {16'(exp_reply), 16'(exp_drop), 16'(exp_ignore)}) begin
         failures++;
         $display("FAIL b2b_counters got=%0d/%0d/%0d exp=%0d/%0d/%0d", reply_count, drop_count,
                  ignore_count, exp_reply, exp_drop, exp_ignore);
      end
      wait_idle("b2b");
   endtask

   // A third frame arrives in the very cycle that HOLDOFF ends while the slot
   // is full. It must move into the freed slot and must not be counted as a drop.
   task automatic test_holdoff_exit_collision;
      frame_t f[3];
      int n[3];
      clear_sb();
      for (int k = 0; k < 3; k++)
         f[k] = req_frame(48'hFFFFFFFFFFFF, {16'h0a00, $urandom()}, $urandom(), MY_IP);
      send_frame(f[0], n[0]);
      wait_cycles(1);
      send_frame(f[1], n[1]);
      wait_cycles((n[0] + 1 + TX_GAP) - n[1] - 2);
      send_frame(f[2], n[2]);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(ref_reply(f[k]));
         exp_cyc_q.push_back(n[0] + 2 + k * (TX_GAP + 1));
      end
      exp_reply += 3;
      last_reply = ref_reply(f[2]);
      wait_cycles(2 * TX_GAP + 20);
      checks++;
      if (obs_cyc_q.size() != exp_cyc_q.size()) begin
         failures++;
         $display("FAIL collide_pulse_count got=%0d exp=%0d", obs_cyc_q.size(), exp_cyc_q.size());
      end else foreach (exp_cyc_q[i]) begin
         checks++;
         if (obs_cyc_q[i] != exp_cyc_q[i]) begin
            failures++;
            $display("FAIL collide_pulse_cycle idx=%0d got=%0d exp=%0d", i, obs_cyc_q[i], exp_cyc_q[i]);
         end
         checks++;
         if (obs_pkt_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL collide_reply idx=%0d got=%h exp=%h", i, obs_pkt_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({reply_count, drop_count} !== {16'(exp_reply), 16'(exp_drop)}) begin
         failures++;
         $display("FAIL collide_counters got=%0d/%0d exp=%0d/%0d", reply_count, drop_count,
                  exp_reply, exp_drop);
      end
      wait_idle("collide");
   endtask

   task automatic test_reset_midflight;
      frame_t a, b;
      int na, nb;
      clear_sb();
      a = req_frame(MY_MAC, 48'h02aabbccddee, 32'h0a1f5510, MY_IP);
      b = req_frame(MY_MAC, 48'h02aabbccddef, 32'h0a1f5511, MY_IP);
      send_frame(a, na);
      wait_cycles(1);
      send_frame(b, nb);
      exp_q.push_back(ref_reply(a)); exp_cyc_q.push_back(na + 2);
      wait_cycles(40);
      #5 rst_in = 1'b1;
      #1;
      exp_reply = 0; exp_drop = 0; exp_ignore = 0;
      checks++;
      if ({tx_transmit, busy, state_dbg} !== 4'b0) begin
         failures++;
         $display("FAIL midreset_ctrl got=%b exp=0000", {tx_transmit, busy, state_dbg});
      end
      checks++;
      if (tx_packet !== 480'h0) begin
         failures++;
         $display("FAIL midreset_tx_packet got=%h exp=0", tx_packet);
      end
      checks++;
      if ({reply_count, drop_count, ignore_count} !== 48'h0) begin
         failures++;
         $display("FAIL midreset_counters got=%h exp=0", {reply_count, drop_count, ignore_count});
      end
      wait_cycles(2);
      #1 rst_in = 1'b0;
      wait_cycles(2 * TX_GAP + 20);
      checks++;
      if (obs_cyc_q.size() != exp_cyc_q.size()) begin
         failures++;
         $display("FAIL midreset_pulse_count got=%0d exp=%0d", obs_cyc_q.size(), exp_cyc_q.size());
      end else foreach (exp_cyc_q[i]) begin
         checks++;
         if (obs_cyc_q[i] != exp_cyc_q[i]) begin
            failures++;
            $display("FAIL midreset_pulse_cycle got=%0d exp=%0d", obs_cyc_q[i], exp_cyc_q[i]);
         end
      end
      checks++;
      if ({busy, reply_count} !== 17'h0) begin
         failures++;
         $display("FAIL midreset_after busy=%b replies=%0d exp=0/0", busy, reply_count);
      end
      last_reply = '0;
   endtask

   task automatic test_random;
      frame_t f;
      int n, sel;
      for (int it = 0; it < 20; it++) begin
         clear_sb();
         f = req_frame(($urandom_range(0, 1) == 1) ? MY_MAC : 48'hFFFFFFFFFFFF,
                       {$urandom_range(0, 16'hFFFF), $urandom()}, $urandom(), MY_IP);
         f.src = {16'h0002, $urandom()};
         f.tha = {$urandom_range(0, 16'hFFFF), $urandom()};
         f.pad = {5{$urandom()}};
         sel = $urandom_range(0, 8);
         case (sel)
            3: f.tpa = f.tpa ^ (32'd1 << $urandom_range(0, 31));
            4: f.typ = 16'h0800;
            5: f.oper = 16'h0002;
            6: f.hlen = f.hlen ^ (8'd1 << $urandom_range(0, 7));
            7: f.dst = {16'h0200, $urandom()};
            8: f.ptype = f.ptype ^ (16'd1 << $urandom_range(0, 15));
            default: ;
         endcase
         send_frame(f, n);
         if (ref_match(f)) begin
            exp_q.push_back(ref_reply(f)); exp_cyc_q.push_back(n + 2);
            exp_reply++;
            last_reply = ref_reply(f);
         end else begin
            exp_ignore++;
         end
         wait_cycles(4);
         checks++;
         if (obs_cyc_q.size() != exp_cyc_q.size()) begin
            failures++;
            $display("FAIL rand_pulse_count it=%0d sel=%0d got=%0d exp=%0d", it, sel,
                     obs_cyc_q.size(), exp_cyc_q.size());
         end else foreach (exp_cyc_q[i]) begin
            checks++;
            if (obs_cyc_q[i] != exp_cyc_q[i]) begin
               failures++;
               $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, obs_cyc_q[i], exp_cyc_q[i]);
            end
            checks++;
            if (obs_pkt_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL rand_reply it=%0d got=%h exp=%h", it, obs_pkt_q[i], exp_q[i]);
            end
         end
         checks++;
         if (tx_packet !== last_reply) begin
            failures++;
            $display("FAIL rand_tx_hold it=%0d got=%h exp=%h", it, tx_packet, last_reply);
         end
         checks++;
         if ({reply_count, drop_count, ignore_count} !==
             {16'(exp_reply), 16'(exp_drop), 16'(exp_ignore)}) begin
            failures++;
            $display("FAIL rand_counters it=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, reply_count,
                     drop_count, ignore_count, exp_reply, exp_drop, exp_ignore);
         end
         wait_idle("rand");
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_unicast();
      test_filtering();
      test_back_to_back();
      test_holdoff_exit_collision();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
